// File: rtl/writeback_unit_if.sv
// Result-source bus into the writeback unit: ALU and load paths with valid/ready handshakes.
// The master modport belongs to the producing pipeline stages; the writeback unit uses the slave modport.
interface writeback_unit_if #(
  parameter int Width = 32,
  parameter int Depth = 32
);
  localparam int AW = $clog2(Depth);

  logic             alu_valid;
  logic             alu_ready;
  logic [AW-1:0]    alu_rd;
  logic [Width-1:0] alu_data;
  logic             ld_valid;
  logic             ld_ready;
  logic [AW-1:0]    ld_rd;
  logic [Width-1:0] ld_data;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_offset;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_offset,
    input  alu_ready, ld_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_offset,
    output alu_ready, ld_ready
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU/load results, formats RV32 load data, drives a registered register-file
// write port, and tracks pending writes per register. Define WB_BYPASS_EN to add rs1/rs2 forwarding ports.
module writeback_unit #(
  parameter int Width = 32,
  parameter int Depth = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  writeback_unit_if.slave            src,
  input  logic                       issue_valid,
  input  logic [$clog2(Depth)-1:0]   issue_rd,
  output logic                       issue_ready,
  output logic                       wr_en,
  output logic [$clog2(Depth)-1:0]   wr_addr,
  output logic [Width-1:0]           wr_data,
  input  logic [$clog2(Depth)-1:0]   rs1_addr,
  input  logic [$clog2(Depth)-1:0]   rs2_addr,
  output logic                       rs1_busy,
  output logic                       rs2_busy
`ifdef WB_BYPASS_EN
  ,
  output logic                       rs1_fwd,
  output logic [Width-1:0]           rs1_fwd_data,
  output logic                       rs2_fwd,
  output logic [Width-1:0]           rs2_fwd_data
`endif
);
  localparam int AW = $clog2(Depth);

  logic             ld_fire;
  logic             alu_fire;
  logic             issue_fire;
  logic             dec_fire;
  logic [AW-1:0]    xfer_rd;
  logic [Width-1:0] xfer_data;

  logic             wr_en_d, wr_en_q;
  logic [AW-1:0]    wr_addr_d, wr_addr_q;
  logic [Width-1:0] wr_data_d, wr_data_q;
  logic [1:0]       cnt_d [Depth];
  logic [1:0]       cnt_q [Depth];

  function automatic logic [Width-1:0] fmt_load(input logic [Width-1:0] d,
                                                input logic [2:0]       f3,
                                                input logic [1:0]       off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  fmt_load = {{(Width-8){b[7]}}, b};
      3'b100:  fmt_load = {{(Width-8){1'b0}}, b};
      3'b001:  fmt_load = {{(Width-16){h[15]}}, h};
      3'b101:  fmt_load = {{(Width-16){1'b0}}, h};
      default: fmt_load = d;
    endcase
  endfunction

  // Load path has fixed priority; the ALU waits whenever a load is presented.
  assign src.ld_ready  = 1'b1;
  assign src.alu_ready = !src.ld_valid;
  assign ld_fire       = src.ld_valid;
  assign alu_fire      = src.alu_valid && !src.ld_valid;

  always_comb begin
    xfer_rd   = src.alu_rd;
    xfer_data = src.alu_data;
    if (ld_fire) begin
      xfer_rd   = src.ld_rd;
      xfer_data = fmt_load(src.ld_data, src.ld_funct3, src.ld_offset);
    end
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (ld_fire || alu_fire) begin
      wr_en_d   = (xfer_rd != '0);
      wr_addr_d = xfer_rd;
      wr_data_d = xfer_data;
    end
  end

  // wr_en is only ever raised for a non-zero address, so it is the decrement strobe directly.
  assign dec_fire    = wr_en_q;
  assign issue_ready = !((cnt_q[issue_rd] == 2'd3) && !(dec_fire && (wr_addr_q == issue_rd)));
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0) begin
        cnt_d[i] = 2'd0;
      end else if (issue_fire && (issue_rd == AW'(i))) begin
        if (!(dec_fire && (wr_addr_q == AW'(i)))) cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (dec_fire && (wr_addr_q == AW'(i)) && (cnt_q[i] != 2'd0)) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < Depth; i++) cnt_q[i] <= 2'd0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef WB_BYPASS_EN
  // Last outstanding write landing this cycle can be forwarded instead of stalling the reader.
  assign rs1_fwd      = wr_en_q && (wr_addr_q == rs1_addr) && (rs1_addr != '0) && (cnt_q[rs1_addr] == 2'd1);
  assign rs2_fwd      = wr_en_q && (wr_addr_q == rs2_addr) && (rs2_addr != '0) && (cnt_q[rs2_addr] == 2'd1);
  assign rs1_fwd_data = wr_data_q;
  assign rs2_fwd_data = wr_data_q;
  assign rs1_busy     = (rs1_addr != '0) && (cnt_q[rs1_addr] != 2'd0) && !rs1_fwd;
  assign rs2_busy     = (rs2_addr != '0) && (cnt_q[rs2_addr] != 2'd0) && !rs2_fwd;
`else
  assign rs1_busy     = (rs1_addr != '0) && (cnt_q[rs1_addr] != 2'd0);
  assign rs2_busy     = (rs2_addr != '0) && (cnt_q[rs2_addr] != 2'd0);
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: expected register-file writes are queued when a source is driven
// and popped when wr_en appears; hazard and handshake outputs are checked at each step.
module tb_writeback_unit;
  localparam int Width = 32;
  localparam int Depth = 32;
  localparam int AW    = $clog2(Depth);

  typedef struct {
    logic [AW-1:0]    addr;
    logic [Width-1:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic             issue_ready;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [Width-1:0] wr_data;
  logic [AW-1:0]    rs1_addr;
  logic [AW-1:0]    rs2_addr;
  logic             rs1_busy;
  logic             rs2_busy;
`ifdef WB_BYPASS_EN
  logic             rs1_fwd;
  logic [Width-1:0] rs1_fwd_data;
  logic             rs2_fwd;
  logic [Width-1:0] rs2_fwd_data;
`endif

  int  total = 0;
  int  bad   = 0;
  wr_t sb[$];

  writeback_unit_if #(.Width(Width), .Depth(Depth)) src ();

  writeback_unit #(.Width(Width), .Depth(Depth)) dut (
    .clk         (clk),
    .rst         (rst),
    .src         (src),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
`ifdef WB_BYPASS_EN
    ,
    .rs1_fwd      (rs1_fwd),
    .rs1_fwd_data (rs1_fwd_data),
    .rs2_fwd      (rs2_fwd),
    .rs2_fwd_data (rs2_fwd_data)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits (bounded) for wr_en, then compares the write against the oldest queued expectation.
  task automatic expect_wr(input string tag);
    int  n;
    wr_t e;
    n = 0;
    while (wr_en !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd1);
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_write"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, "_addr"}, {27'd0, wr_addr}, {27'd0, e.addr});
        chk({tag, "_data"}, wr_data, e.data);
      end
    end
  endtask

  task automatic alu_drive(input logic [AW-1:0] rd, input logic [31:0] d);
    src.alu_valid = 1'b1;
    src.alu_rd    = rd;
    src.alu_data  = d;
  endtask

  task automatic do_alu(input string tag, input logic [AW-1:0] rd, input logic [31:0] d);
    wr_t e;
    alu_drive(rd, d);
    #1;
    chk({tag, "_alu_ready"}, {31'd0, src.alu_ready}, 32'd1);
    e.addr = rd;
    e.data = d;
    sb.push_back(e);
    tick();
    src.alu_valid = 1'b0;
    expect_wr(tag);
  endtask

  task automatic do_ld(input string tag, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] exp);
    wr_t e;
    src.ld_valid  = 1'b1;
    src.ld_rd     = 5'd10;
    src.ld_data   = 32'h80FF7F01;
    src.ld_funct3 = f3;
    src.ld_offset = off;
    #1;
    chk({tag, "_ld_ready"}, {31'd0, src.ld_ready}, 32'd1);
    e.addr = 5'd10;
    e.data = exp;
    sb.push_back(e);
    tick();
    src.ld_valid = 1'b0;
    expect_wr(tag);
  endtask

  task automatic issue_one(input string tag, input logic [AW-1:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    #1;
    chk({tag, "_issue_ready"}, {31'd0, issue_ready}, 32'd1);
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    wr_t e;
    rst           = 1'b1;
    issue_valid   = 1'b0;
    issue_rd      = '0;
    rs1_addr      = '0;
    rs2_addr      = '0;
    src.alu_valid = 1'b0;
    src.alu_rd    = '0;
    src.alu_data  = '0;
    src.ld_valid  = 1'b0;
    src.ld_rd     = '0;
    src.ld_data   = '0;
    src.ld_funct3 = '0;
    src.ld_offset = '0;

    // Reset state
    @(negedge clk);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_ld_ready", {31'd0, src.ld_ready}, 32'd1);
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // Reset during the wr_en cycle discards the write and the scoreboard
    issue_one("rmw_issue", 5'd5);
    rs1_addr = 5'd5;
    #1;
    chk("rmw_busy_before", {31'd0, rs1_busy}, 32'd1);
    alu_drive(5'd5, 32'h1234);
    #1;
    chk("rmw_alu_ready", {31'd0, src.alu_ready}, 32'd1);
    e.addr = 5'd5;
    e.data = 32'h1234;
    sb.push_back(e);
    tick();
    src.alu_valid = 1'b0;
    expect_wr("rmw");
    rst = 1'b1;
    #1;
    chk("rmw_wr_en_async", {31'd0, wr_en}, 32'd0);
    chk("rmw_wr_addr_async", {27'd0, wr_addr}, 32'd0);
    chk("rmw_wr_data_async", wr_data, 32'd0);
    chk("rmw_busy_after", {31'd0, rs1_busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rmw_no_write", {31'd0, wr_en}, 32'd0);
    end

    // Load formatting
    do_ld("lb_off3", 3'b000, 2'd3, 32'hFFFFFF80);
    do_ld("lbu_off3", 3'b100, 2'd3, 32'h00000080);
    do_ld("lhu_off2", 3'b101, 2'd2, 32'h000080FF);
    do_ld("lh_off0", 3'b001, 2'd0, 32'h00007F01);
    do_ld("lh_off2", 3'b001, 2'd2, 32'hFFFF80FF);
    do_ld("lb_off1", 3'b000, 2'd1, 32'h0000007F);
    do_ld("lw_off1", 3'b010, 2'd1, 32'h80FF7F01);
    do_ld("f3_011", 3'b011, 2'd2, 32'h80FF7F01);

    // Arbitration: load wins, ALU follows one cycle later
    src.ld_valid  = 1'b1;
    src.ld_rd     = 5'd3;
    src.ld_data   = 32'h11112222;
    src.ld_funct3 = 3'b010;
    src.ld_offset = 2'd0;
    alu_drive(5'd4, 32'h33334444);
    #1;
    chk("arb_alu_blocked", {31'd0, src.alu_ready}, 32'd0);
    e.addr = 5'd3;
    e.data = 32'h11112222;
    sb.push_back(e);
    tick();
    src.ld_valid = 1'b0;
    #1;
    chk("arb_alu_ready", {31'd0, src.alu_ready}, 32'd1);
    e.addr = 5'd4;
    e.data = 32'h33334444;
    sb.push_back(e);
    expect_wr("arb_ld");
    tick();
    src.alu_valid = 1'b0;
    expect_wr("arb_alu");

    // Scoreboard saturation and simultaneous issue/complete
    issue_one("sb_i1", 5'd7);
    issue_one("sb_i2", 5'd7);
    issue_one("sb_i3", 5'd7);
    issue_rd = 5'd7;
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    #1;
    chk("sb_full_ready", {31'd0, issue_ready}, 32'd0);
    chk("sb_full_busy1", {31'd0, rs1_busy}, 32'd1);
    chk("sb_full_busy2", {31'd0, rs2_busy}, 32'd1);
    alu_drive(5'd7, 32'h70);
    e.addr = 5'd7;
    e.data = 32'h70;
    sb.push_back(e);
    tick();
    src.alu_valid = 1'b0;
    #1;
    chk("sb_ready_on_dec", {31'd0, issue_ready}, 32'd1);
    expect_wr("sb_w1");
    tick();
    chk("sb_cnt2_busy", {31'd0, rs1_busy}, 32'd1);
    chk("sb_cnt2_ready", {31'd0, issue_ready}, 32'd1);
    alu_drive(5'd7, 32'h71);
    e.addr = 5'd7;
    e.data = 32'h71;
    sb.push_back(e);
    tick();
    src.alu_valid = 1'b0;
    issue_valid   = 1'b1;
    issue_rd      = 5'd7;
    #1;
    chk("sb_same_ready", {31'd0, issue_ready}, 32'd1);
    expect_wr("sb_w2");
    tick();
    issue_valid = 1'b0;
    #1;
    chk("sb_same_unchanged", {31'd0, issue_ready}, 32'd1);
    issue_one("sb_i4", 5'd7);
    #1;
    chk("sb_refill_ready", {31'd0, issue_ready}, 32'd0);
    do_alu("sb_d1", 5'd7, 32'h72);
    do_alu("sb_d2", 5'd7, 32'h73);
    do_alu("sb_d3", 5'd7, 32'h74);
    tick();
    chk("sb_drained_busy1", {31'd0, rs1_busy}, 32'd0);
    chk("sb_drained_busy2", {31'd0, rs2_busy}, 32'd0);

    // x0 and untracked registers
    issue_one("x0_issue", 5'd0);
    rs1_addr = 5'd0;
    #1;
    chk("x0_busy", {31'd0, rs1_busy}, 32'd0);
    alu_drive(5'd0, 32'hDEAD);
    #1;
    chk("x0_alu_ready", {31'd0, src.alu_ready}, 32'd1);
    tick();
    src.alu_valid = 1'b0;
    chk("x0_no_wr_en", {31'd0, wr_en}, 32'd0);
    rs1_addr = 5'd9;
    do_alu("untracked", 5'd9, 32'h99);
    tick();
    chk("untracked_busy", {31'd0, rs1_busy}, 32'd0);
    issue_one("untracked_issue", 5'd9);
    chk("untracked_cnt1", {31'd0, rs1_busy}, 32'd1);
    do_alu("untracked_clear", 5'd9, 32'h9A);
    tick();
    chk("untracked_cleared", {31'd0, rs1_busy}, 32'd0);

    // Busy/forwarding during the wr_en cycle of the last outstanding write
    issue_one("byp_issue", 5'd6);
    rs1_addr = 5'd6;
    rs2_addr = 5'd6;
    alu_drive(5'd6, 32'hABCD);
    e.addr = 5'd6;
    e.data = 32'hABCD;
    sb.push_back(e);
    tick();
    src.alu_valid = 1'b0;
`ifdef WB_BYPASS_EN
    chk("byp_fwd1", {31'd0, rs1_fwd}, 32'd1);
    chk("byp_fwd1_data", rs1_fwd_data, 32'hABCD);
    chk("byp_fwd2", {31'd0, rs2_fwd}, 32'd1);
    chk("byp_busy1", {31'd0, rs1_busy}, 32'd0);
    chk("byp_busy2", {31'd0, rs2_busy}, 32'd0);
`else
    chk("nobyp_busy1", {31'd0, rs1_busy}, 32'd1);
    chk("nobyp_busy2", {31'd0, rs2_busy}, 32'd1);
`endif
    expect_wr("byp");
    tick();
    chk("byp_after_busy", {31'd0, rs1_busy}, 32'd0);
    chk("sb_queue_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
